// File: rtl/userio_ps2_cmdarb.sv
// PS/2 command arbiter: round-robin grant between the init sequencer and the host,
// sends the byte, waits for ACK/RESEND with timeout and retries, forwards other traffic.
module userio_ps2_cmdarb #(
  parameter logic [15:0] ACK_TIMEOUT = 16'd40000,
  parameter logic [1:0]  MAX_RETRY   = 2'd2
) (
  input  logic        clk,
  input  logic        clk7_en,
  input  logic        _reset,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  output logic [1:0]  req_grant,
  output logic [1:0]  req_done,
  output logic        req_err,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_done,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        fwd_valid,
  output logic [7:0]  fwd_data,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // Handshake: req_valid is a level request, req_grant/req_done/tx_start/fwd_valid are
  // one-tick pulses; tx_done/rx_valid are one-tick pulses from the PS/2 shifters.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_TX  = 3'd2,
    WAIT_ACK = 3'd3,
    FINISH   = 3'd4
  } state_t;

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;

  state_t      state, state_d;
  logic [15:0] timer, timer_d;
  logic [16:0] timer_inc;
  logic [1:0]  retry, retry_d;
  logic        owner, owner_d;
  logic        err, err_d;
  logic        pick;

  logic [1:0]  req_grant_d, req_done_d;
  logic        req_err_d, tx_start_d, fwd_valid_d;
  logic [7:0]  tx_data_d, fwd_data_d;

  assign dbg_state = state;
  assign timer_inc = {1'b0, timer} + 17'd1;

  always_comb begin
    state_d     = state;
    timer_d     = timer;
    retry_d     = retry;
    owner_d     = owner;
    err_d       = err;
    pick        = owner;
    req_grant_d = 2'b00;
    req_done_d  = 2'b00;
    req_err_d   = 1'b0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data;
    fwd_valid_d = 1'b0;
    fwd_data_d  = fwd_data;

    // ACK/RESEND are consumed only while a reply is awaited; everything else goes on
    if (rx_valid && !(state == WAIT_ACK &&
                      (rx_data == BYTE_ACK || rx_data == BYTE_RESEND))) begin
      fwd_valid_d = 1'b1;
      fwd_data_d  = rx_data;
    end

    case (state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          // owner holds the last granted requester, so a tie goes to the other one
          pick        = (req_valid == 2'b11) ? ~owner : req_valid[1];
          owner_d     = pick;
          req_grant_d = pick ? 2'b10 : 2'b01;
          tx_data_d   = pick ? req_data[15:8] : req_data[7:0];
          retry_d     = 2'd0;
          err_d       = 1'b0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (tx_done) begin
          timer_d = 16'd0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        timer_d = timer_inc[16] ? timer : timer_inc[15:0];
        if (rx_valid && rx_data == BYTE_ACK) begin
          err_d   = 1'b0;
          state_d = FINISH;
        end else if (rx_valid && rx_data == BYTE_RESEND) begin
          if (retry < MAX_RETRY) begin
            retry_d = retry + 2'd1;
            state_d = SEND;
          end else begin
            err_d   = 1'b1;
            state_d = FINISH;
          end
        end else if (!rx_valid && timer_inc >= {1'b0, ACK_TIMEOUT}) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH: begin
        req_done_d = owner ? 2'b10 : 2'b01;
        req_err_d  = err;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (!_reset) begin
        state     <= IDLE;
        timer     <= 16'd0;
        retry     <= 2'd0;
        owner     <= 1'b1;
        err       <= 1'b0;
        req_grant <= 2'b00;
        req_done  <= 2'b00;
        req_err   <= 1'b0;
        tx_start  <= 1'b0;
        tx_data   <= 8'h00;
        fwd_valid <= 1'b0;
        fwd_data  <= 8'h00;
        busy      <= 1'b0;
      end else begin
        state     <= state_d;
        timer     <= timer_d;
        retry     <= retry_d;
        owner     <= owner_d;
        err       <= err_d;
        req_grant <= req_grant_d;
        req_done  <= req_done_d;
        req_err   <= req_err_d;
        tx_start  <= tx_start_d;
        tx_data   <= tx_data_d;
        fwd_valid <= fwd_valid_d;
        fwd_data  <= fwd_data_d;
        busy      <= (state_d != IDLE);
      end
    end
  end

endmodule

// File: tb/tb_userio_ps2_cmdarb.sv
// Directed bench for userio_ps2_cmdarb: grant/ack flow, round-robin, resend,
// reply timeout, forwarding and mid-command reset.
module tb_userio_ps2_cmdarb;

  localparam logic [15:0] T_ACK = 16'd30;

  logic        clk = 1'b0;
  logic        clk7_en, _reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_grant, req_done;
  logic        req_err, tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy, tx_done, rx_valid;
  logic [7:0]  rx_data;
  logic        fwd_valid;
  logic [7:0]  fwd_data;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int n_grant, n_start, n_done, n_fwd;
  logic tick_seen = 1'b0;
  logic [7:0] exp_q[$];

  logic [1:0] g;
  logic [7:0] b;
  logic       e;

  userio_ps2_cmdarb #(.ACK_TIMEOUT(T_ACK), .MAX_RETRY(2'd2)) dut (
    .clk(clk), .clk7_en(clk7_en), ._reset(_reset),
    .req_valid(req_valid), .req_data(req_data),
    .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pulse counters and forwarded-byte scoreboard, sampled mid-cycle after each tick
  always @(posedge clk) tick_seen <= clk7_en;

  always @(negedge clk) begin
    if (tick_seen) begin
      if (req_grant != 2'b00) n_grant++;
      if (tx_start)           n_start++;
      if (req_done != 2'b00)  n_done++;
      if (fwd_valid) begin
        n_fwd++;
        if (exp_q.size() == 0) check("fwd_unexpected", 32'(exp_q.size()), 1);
        else                   check("fwd_data", fwd_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_grant = 0; n_start = 0; n_done = 0; n_fwd = 0;
  endtask

  task automatic do_reset();
    _reset = 1'b0;
    step();
    step();
    _reset = 1'b1;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 20 && !tx_start; i++) step();
    check(tag, 32'(tx_start), 1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && req_done == 2'b00; i++) step();
    check(tag, 32'(req_done != 2'b00), 1);
  endtask

  // one command answered with ACK; returns grant, latched byte and error flag
  task automatic run_cmd(input string tag, input logic [1:0] rv, input logic [15:0] rd,
                         input bit keep, output logic [1:0] gnt, output logic [7:0] txd,
                         output logic err);
    req_valid = rv;
    req_data  = rd;
    step();
    for (int i = 0; i < 20 && req_grant == 2'b00; i++) step();
    check({tag, "_grant_seen"}, 32'(req_grant != 2'b00), 1);
    gnt = req_grant;
    txd = tx_data;
    if (!keep) req_valid = 2'b00;
    wait_start({tag, "_start_seen"});
    step();
    tx_done = 1'b1; step(); tx_done = 1'b0;
    rx_valid = 1'b1; rx_data = 8'hFA; step(); rx_valid = 1'b0;
    wait_done({tag, "_done_seen"});
    err = req_err;
  endtask

  // bring a fresh command from requester 0 to the reply wait
  task automatic to_wait_ack(input logic [7:0] cmd);
    req_valid = 2'b01; req_data = {8'h00, cmd};
    step();
    check("wa_grant", req_grant, 2'b01);
    req_valid = 2'b00;
    wait_start("wa_start");
    step();
    tx_done = 1'b1; step(); tx_done = 1'b0;
    check("wa_state", dbg_state, 3);
  endtask

  initial begin
    clk7_en = 1'b1; _reset = 1'b0;
    req_valid = 2'b00; req_data = 16'h0000;
    tx_busy = 1'b0; tx_done = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // reset state
    do_reset();
    check("rst_pulses", {req_grant, req_done, req_err, tx_start, fwd_valid, busy}, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_fwd_data", fwd_data, 8'h00);
    check("rst_state", dbg_state, 0);

    // single command F4 acknowledged
    clear_counts();
    req_valid = 2'b01; req_data = 16'h00F4;
    step();
    check("a_grant", req_grant, 2'b01);
    check("a_tx_data", tx_data, 8'hF4);
    check("a_busy", busy, 1);
    req_valid = 2'b00;
    step();
    check("a_tx_start", tx_start, 1);
    step();
    check("a_tx_start_end", tx_start, 0);
    tx_done = 1'b1; step(); tx_done = 1'b0;
    check("a_wait_ack", dbg_state, 3);
    rx_valid = 1'b1; rx_data = 8'hFA; step(); rx_valid = 1'b0;
    check("a_finish", dbg_state, 4);
    step();
    check("a_done", req_done, 2'b01);
    check("a_err", req_err, 0);
    check("a_tx_data_hold", tx_data, 8'hF4);
    check("a_idle_busy", busy, 0);
    step();
    check("a_done_end", req_done, 2'b00);
    check("a_n_grant", n_grant, 1);
    check("a_n_start", n_start, 1);
    check("a_n_done", n_done, 1);
    check("a_n_fwd", n_fwd, 0);

    // round-robin with both requesters held valid
    do_reset();
    run_cmd("rr1", 2'b11, 16'hEDF4, 1'b1, g, b, e);
    check("rr1_gnt", g, 2'b01); check("rr1_byte", b, 8'hF4); check("rr1_err", e, 0);
    run_cmd("rr2", 2'b11, 16'hEDF4, 1'b1, g, b, e);
    check("rr2_gnt", g, 2'b10); check("rr2_byte", b, 8'hED); check("rr2_done", req_done, 2'b10);
    run_cmd("rr3", 2'b11, 16'hEDF4, 1'b0, g, b, e);
    check("rr3_gnt", g, 2'b01); check("rr3_byte", b, 8'hF4);
    step();

    // resend exhausted: FF answered FE three times
    clear_counts();
    req_valid = 2'b01; req_data = 16'h00FF;
    step();
    check("rs_grant", req_grant, 2'b01);
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      wait_start("rs_start_seen");
      check("rs_tx_data", tx_data, 8'hFF);
      step();
      tx_done = 1'b1; step(); tx_done = 1'b0;
      rx_valid = 1'b1; rx_data = 8'hFE; step(); rx_valid = 1'b0;
    end
    step();
    check("rs_done", req_done, 2'b01);
    check("rs_err", req_err, 1);
    step();
    check("rs_n_start", n_start, 3);
    check("rs_n_done", n_done, 1);
    check("rs_n_fwd", n_fwd, 0);

    // reply timeout
    to_wait_ack(8'hF2);
    repeat (T_ACK - 1) step();
    check("to_not_early", dbg_state, 3);
    step();
    check("to_finish", dbg_state, 4);
    step();
    check("to_done", req_done, 2'b01);
    check("to_err", req_err, 1);

    // ACK on the exact timeout tick wins
    step();
    to_wait_ack(8'hF3);
    repeat (T_ACK - 1) step();
    rx_valid = 1'b1; rx_data = 8'hFA; step(); rx_valid = 1'b0;
    check("tl_finish", dbg_state, 4);
    step();
    check("tl_done", req_done, 2'b01);
    check("tl_err", req_err, 0);
    step();

    // forwarding in IDLE and in WAIT_ACK
    clear_counts();
    rx_valid = 1'b1; rx_data = 8'h08; exp_q.push_back(8'h08); step(); rx_valid = 1'b0;
    check("fw_idle_valid", fwd_valid, 1);
    check("fw_idle_data", fwd_data, 8'h08);
    to_wait_ack(8'hF4);
    rx_valid = 1'b1; rx_data = 8'hAA; exp_q.push_back(8'hAA); step(); rx_valid = 1'b0;
    check("fw_ack_valid", fwd_valid, 1);
    check("fw_ack_data", fwd_data, 8'hAA);
    check("fw_ack_stay", dbg_state, 3);
    rx_valid = 1'b1; rx_data = 8'hFA; step(); rx_valid = 1'b0;
    step();
    check("fw_done", req_done, 2'b01);
    check("fw_err", req_err, 0);
    step();
    check("fw_n_fwd", n_fwd, 2);
    check("fw_q_empty", 32'(exp_q.size()), 0);

    // reset during WAIT_ACK, then requester 1 with enable gaps and busy shifter
    to_wait_ack(8'hF4);
    clear_counts();
    _reset = 1'b0; req_valid = 2'b10; req_data = 16'hF500;
    step();
    check("mr_outs", {req_grant, req_done, req_err, tx_start, fwd_valid, busy}, 0);
    check("mr_tx_data", tx_data, 8'h00);
    check("mr_state", dbg_state, 0);
    _reset = 1'b1;
    step();
    check("mr_grant", req_grant, 2'b10);
    check("mr_tx_data_new", tx_data, 8'hF5);
    req_valid = 2'b00; tx_busy = 1'b1;
    clk7_en = 1'b0;
    repeat (3) step();
    check("mr_hold_grant", req_grant, 2'b10);
    check("mr_hold_start", tx_start, 0);
    clk7_en = 1'b1;
    step();
    check("mr_busy_wait", {req_grant, tx_start}, 0);
    check("mr_busy_state", dbg_state, 1);
    tx_busy = 1'b0;
    step();
    check("mr_start", tx_start, 1);
    step();
    tx_done = 1'b1; step(); tx_done = 1'b0;
    rx_valid = 1'b1; rx_data = 8'hFA; step(); rx_valid = 1'b0;
    step();
    check("mr_done", req_done, 2'b10);
    check("mr_err", req_err, 0);
    step();
    check("mr_n_done", n_done, 1);
    check("mr_n_grant", n_grant, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
